// File: rtl/dart_scoreboard.sv
// Two-player countdown dart scoreboard: alternating turns, bust restores the
// score the turn started with, and the first player to land exactly on zero wins.
module dart_scoreboard #(
    parameter int START_SCORE     = 15,
    parameter int SCORE_W         = 5,
    parameter int THROWS_PER_TURN = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               throw_valid,
    input  logic [1:0]         points,
    output logic               throw_ready,
    output logic [SCORE_W-1:0] score_a,
    output logic [SCORE_W-1:0] score_b,
    output logic               cur_player,
    output logic [1:0]         throw_idx,
    output logic               turn_done,
    output logic               bust,
    output logic               game_over,
    output logic               winner,
    output logic [1:0]         fsm_state
);

    localparam logic [SCORE_W-1:0] START_VAL = SCORE_W'(START_SCORE);
    localparam logic [1:0]         LAST_IDX  = 2'(THROWS_PER_TURN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [SCORE_W-1:0] score_a_next, score_b_next;
    logic [SCORE_W-1:0] turn_start, turn_start_next;
    logic [SCORE_W-1:0] cur_score, other_score, pts_ext, new_score;
    logic               cur_player_next;
    logic [1:0]         throw_idx_next;
    logic               turn_done_next, bust_next, winner_next;
    logic               reload, end_turn;

    // Throw handshake: a throw is consumed on any rising edge where
    // throw_valid and throw_ready are both high and start is low.
    assign throw_ready = (state == PLAY);
    assign game_over   = (state == OVER);
    assign fsm_state   = state;

    always_comb begin
        state_next      = state;
        score_a_next    = score_a;
        score_b_next    = score_b;
        turn_start_next = turn_start;
        cur_player_next = cur_player;
        throw_idx_next  = throw_idx;
        turn_done_next  = 1'b0;
        bust_next       = 1'b0;
        winner_next     = winner;
        reload          = 1'b0;
        end_turn        = 1'b0;
        cur_score       = cur_player ? score_b : score_a;
        other_score     = cur_player ? score_a : score_b;
        pts_ext         = SCORE_W'(points);
        new_score       = cur_score;

        case (state)
            IDLE, OVER: begin
                if (start) reload = 1'b1;
            end
            PLAY: begin
                if (start) begin
                    reload = 1'b1;
                end else if (throw_valid) begin
                    if (pts_ext > cur_score) begin
                        new_score = turn_start;
                        bust_next = 1'b1;
                        end_turn  = 1'b1;
                    end else if (pts_ext == cur_score) begin
                        new_score   = '0;
                        state_next  = OVER;
                        winner_next = cur_player;
                    end else begin
                        new_score = cur_score - pts_ext;
                        if (throw_idx == LAST_IDX) end_turn = 1'b1;
                        else throw_idx_next = throw_idx + 2'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (cur_player) score_b_next = new_score;
        else score_a_next = new_score;

        // The incoming player's score becomes the bust-restore point.
        if (end_turn) begin
            turn_done_next  = 1'b1;
            cur_player_next = ~cur_player;
            throw_idx_next  = 2'd0;
            turn_start_next = other_score;
        end

        if (reload) begin
            state_next      = PLAY;
            score_a_next    = START_VAL;
            score_b_next    = START_VAL;
            turn_start_next = START_VAL;
            cur_player_next = 1'b0;
            throw_idx_next  = 2'd0;
            turn_done_next  = 1'b0;
            bust_next       = 1'b0;
            winner_next     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            score_a    <= START_VAL;
            score_b    <= START_VAL;
            turn_start <= START_VAL;
            cur_player <= 1'b0;
            throw_idx  <= 2'd0;
            turn_done  <= 1'b0;
            bust       <= 1'b0;
            winner     <= 1'b0;
        end else begin
            state      <= state_next;
            score_a    <= score_a_next;
            score_b    <= score_b_next;
            turn_start <= turn_start_next;
            cur_player <= cur_player_next;
            throw_idx  <= throw_idx_next;
            turn_done  <= turn_done_next;
            bust       <= bust_next;
            winner     <= winner_next;
        end
    end

endmodule

// File: tb/tb_dart_scoreboard.sv
// Bench for dart_scoreboard: fixed game vectors, reset corner sequence, then
// random play checked against a game-level model through an expected queue.
module tb_dart_scoreboard;

    localparam int SCORE_W = 5;
    localparam int START   = 15;
    localparam int TPT     = 3;
    localparam int EW      = 20;

    logic               clk;
    logic               rst;
    logic               start;
    logic               throw_valid;
    logic [1:0]         points;
    logic               throw_ready;
    logic [SCORE_W-1:0] score_a;
    logic [SCORE_W-1:0] score_b;
    logic               cur_player;
    logic [1:0]         throw_idx;
    logic               turn_done;
    logic               bust;
    logic               game_over;
    logic               winner;
    logic [1:0]         fsm_state;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [EW-1:0] exp_q[$];

    typedef struct {
        bit s, v;
        logic [1:0] p;
        bit rdy;
        int sa, sb;
        bit cp;
        int idx;
        bit td, bu, go, w;
        int st;
    } vec_t;
    vec_t tbl[$];

    // Game-level reference model: phase 0 idle, 1 playing, 2 over
    int m_phase;
    int m_score[2];
    int m_cp, m_idx, m_base, m_win;
    bit m_td, m_bu;

    dart_scoreboard #(.START_SCORE(START), .SCORE_W(SCORE_W), .THROWS_PER_TURN(TPT)) dut (
        .clk(clk), .rst(rst), .start(start), .throw_valid(throw_valid), .points(points),
        .throw_ready(throw_ready), .score_a(score_a), .score_b(score_b),
        .cur_player(cur_player), .throw_idx(throw_idx), .turn_done(turn_done),
        .bust(bust), .game_over(game_over), .winner(winner), .fsm_state(fsm_state)
    );

    // clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [EW-1:0] pack(bit rdy, int sa, int sb, bit cp, int idx,
                                           bit td, bit bu, bit go, bit w, int st);
        return {rdy, 5'(sa), 5'(sb), cp, 2'(idx), td, bu, go, w, 2'(st)};
    endfunction

    task automatic check(string tag, string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s %s: got %0d expected %0d", tag, name, act, exp);
        end
    endtask

    task automatic compare_outputs(string tag);
        logic [EW-1:0] e, a;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s expected queue empty", tag);
            return;
        end
        e = exp_q.pop_front();
        a = pack(throw_ready, score_a, score_b, cur_player, throw_idx, turn_done, bust,
                 game_over, winner, fsm_state);
        check(tag, "throw_ready", a[19], e[19]);
        check(tag, "score_a", a[18:14], e[18:14]);
        check(tag, "score_b", a[13:9], e[13:9]);
        check(tag, "cur_player", a[8], e[8]);
        check(tag, "throw_idx", a[7:6], e[7:6]);
        check(tag, "turn_done", a[5], e[5]);
        check(tag, "bust", a[4], e[4]);
        check(tag, "game_over", a[3], e[3]);
        check(tag, "winner", a[2], e[2]);
        check(tag, "state", a[1:0], e[1:0]);
    endtask

    // driver: inputs change 1 time unit after the edge, outputs read there too
    task automatic apply(input bit r, input bit s, input bit v, input logic [1:0] p);
        rst         = r;
        start       = s;
        throw_valid = v;
        points      = p;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_phase    = 0;
        m_score[0] = START;
        m_score[1] = START;
        m_cp       = 0;
        m_idx      = 0;
        m_base     = START;
        m_win      = 0;
        m_td       = 0;
        m_bu       = 0;
    endtask

    task automatic model_step(input bit r, input bit s, input bit v, input int p);
        int cur;
        m_td = 0;
        m_bu = 0;
        if (r) begin
            model_reset();
        end else if (s) begin
            model_reset();
            m_phase = 1;
        end else if (m_phase == 1 && v) begin
            cur = m_score[m_cp];
            if (p > cur) begin
                m_score[m_cp] = m_base;
                m_bu = 1;
                m_td = 1;
                m_cp = 1 - m_cp;
                m_idx = 0;
                m_base = m_score[m_cp];
            end else if (p == cur) begin
                m_score[m_cp] = 0;
                m_phase = 2;
                m_win = m_cp;
            end else begin
                m_score[m_cp] = cur - p;
                m_idx++;
                if (m_idx == TPT) begin
                    m_td = 1;
                    m_cp = 1 - m_cp;
                    m_idx = 0;
                    m_base = m_score[m_cp];
                end
            end
        end
        exp_q.push_back(pack(m_phase == 1, m_score[0], m_score[1], m_cp[0], m_idx,
                             m_td, m_bu, m_phase == 2, m_win[0], m_phase));
    endtask

    function automatic void add_row(bit s, bit v, int p, bit rdy, int sa, int sb, bit cp,
                                    int idx, bit td, bit bu, bit go, bit w, int st);
        vec_t t;
        t.s = s; t.v = v; t.p = 2'(p); t.rdy = rdy; t.sa = sa; t.sb = sb; t.cp = cp;
        t.idx = idx; t.td = td; t.bu = bu; t.go = go; t.w = w; t.st = st;
        tbl.push_back(t);
    endfunction

    initial begin
        bit r, s, v;
        int p;

        // idle throw ignored; start; A throws 3,2,1 back to back
        add_row(0,1,3, 0,15,15,0,0,0,0,0,0,0);
        add_row(1,0,0, 1,15,15,0,0,0,0,0,0,1);
        add_row(0,1,3, 1,12,15,0,1,0,0,0,0,1);
        add_row(0,1,2, 1,10,15,0,2,0,0,0,0,1);
        add_row(0,1,1, 1, 9,15,1,0,1,0,0,0,1);
        add_row(0,1,0, 1, 9,15,1,1,0,0,0,0,1);
        add_row(0,1,0, 1, 9,15,1,2,0,0,0,0,1);
        add_row(0,1,0, 1, 9,15,0,0,1,0,0,0,1);
        // A ends turn at 4, B ends at 6, then A busts back to 4
        add_row(0,1,3, 1, 6,15,0,1,0,0,0,0,1);
        add_row(0,1,2, 1, 4,15,0,2,0,0,0,0,1);
        add_row(0,1,0, 1, 4,15,1,0,1,0,0,0,1);
        add_row(0,1,3, 1, 4,12,1,1,0,0,0,0,1);
        add_row(0,1,3, 1, 4, 9,1,2,0,0,0,0,1);
        add_row(0,1,3, 1, 4, 6,0,0,1,0,0,0,1);
        add_row(0,1,2, 1, 2, 6,0,1,0,0,0,0,1);
        add_row(0,1,3, 1, 4, 6,1,0,1,1,0,0,1);
        // B finishes exactly; throw in OVER ignored; restart
        add_row(0,1,3, 1, 4, 3,1,1,0,0,0,0,1);
        add_row(0,1,3, 0, 4, 0,1,1,0,0,1,1,2);
        add_row(0,1,2, 0, 4, 0,1,1,0,0,1,1,2);
        add_row(1,0,0, 1,15,15,0,0,0,0,0,0,1);
        // reach score_a = 11, throw_idx = 1, then start collides with a throw
        add_row(0,1,3, 1,12,15,0,1,0,0,0,0,1);
        add_row(0,1,1, 1,11,15,0,2,0,0,0,0,1);
        add_row(0,1,0, 1,11,15,1,0,1,0,0,0,1);
        add_row(0,1,0, 1,11,15,1,1,0,0,0,0,1);
        add_row(0,1,0, 1,11,15,1,2,0,0,0,0,1);
        add_row(0,1,0, 1,11,15,0,0,1,0,0,0,1);
        add_row(0,1,0, 1,11,15,0,1,0,0,0,0,1);
        add_row(1,1,2, 1,15,15,0,0,0,0,0,0,1);
        // set up B mid-turn at throw_idx 2
        add_row(0,1,0, 1,15,15,0,1,0,0,0,0,1);
        add_row(0,1,0, 1,15,15,0,2,0,0,0,0,1);
        add_row(0,1,0, 1,15,15,1,0,1,0,0,0,1);
        add_row(0,1,0, 1,15,15,1,1,0,0,0,0,1);
        add_row(0,1,0, 1,15,15,1,2,0,0,0,0,1);

        rst = 1'b1; start = 1'b0; throw_valid = 1'b0; points = 2'd0;
        exp_q.push_back(pack(0, 15, 15, 0, 0, 0, 0, 0, 0, 0));
        apply(1, 0, 0, 0);
        compare_outputs("reset");

        foreach (tbl[i]) begin
            exp_q.push_back(pack(tbl[i].rdy, tbl[i].sa, tbl[i].sb, tbl[i].cp, tbl[i].idx,
                                 tbl[i].td, tbl[i].bu, tbl[i].go, tbl[i].w, tbl[i].st));
            apply(0, tbl[i].s, tbl[i].v, tbl[i].p);
            compare_outputs($sformatf("row%0d", i));
        end

        // reset mid-turn with a throw present, then a throw in IDLE
        exp_q.push_back(pack(0, 15, 15, 0, 0, 0, 0, 0, 0, 0));
        apply(1, 0, 1, 3);
        compare_outputs("rst_mid_turn");
        exp_q.push_back(pack(0, 15, 15, 0, 0, 0, 0, 0, 0, 0));
        apply(0, 0, 1, 3);
        compare_outputs("idle_after_rst");

        // random play against the model
        model_reset();
        model_step(1, 0, 0, 0);
        apply(1, 0, 0, 0);
        compare_outputs("rand_reset");
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 499) == 0);
            s = (m_phase == 1) ? ($urandom_range(0, 79) == 0) : ($urandom_range(0, 5) == 0);
            v = ($urandom_range(0, 3) != 0);
            p = $urandom_range(0, 3);
            model_step(r, s, v, p);
            apply(r, s, v, 2'(p));
            compare_outputs($sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
